insn_prefetch_queue: RTL and testbench



---
 rtl/cpu_pkg.sv | 17 +
 rtl/insn_prefetch_queue_if.sv | 25 ++
 rtl/insn_prefetch_queue_fetch_fifo.sv | 77 +++++++
 rtl/insn_prefetch_queue.sv | 102 ++++++++++
 tb/tb_insn_prefetch_queue.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants for the instruction fetch front end.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSN         = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] insn;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/insn_prefetch_queue_if.sv
// Fetch-side bundle: imem request/response, MEM-stage redirect and the decode handshake.
interface insn_prefetch_queue_if;
    import cpu_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_insn;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            id_ready;
    logic            id_valid;
    logic [XLEN-1:0] id_insn;
    logic [XLEN-1:0] id_pc;

    modport master (
        output imem_req, imem_addr, id_valid, id_insn, id_pc,
        input  imem_insn, redirect, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_insn, id_pc,
        output imem_insn, redirect, redirect_pc, id_ready
    );

endinterface

// File: rtl/insn_prefetch_queue_fetch_fifo.sv
// Synchronous FIFO of {pc, insn} entries; head is registered, push-to-head latency is 1 cycle.
// Flush wins over push/pop; the caller guarantees no push when full and no pop when empty.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  fetch_entry_t           push_dat,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Storage carries no reset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && !flush && (count_q == (PW+1)'(DEPTH))));

    underflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && !flush && (count_q == '0)));

endmodule

// File: rtl/insn_prefetch_queue.sv
// Credit-controlled instruction prefetcher: fetch_pc/inflight tracking in front of a {pc, insn} FIFO.
// Latency request->id_valid 2 cycles (1 with PREFETCH_BYPASS_EN); stalls hold the FIFO and stop issue; redirect flushes.
module insn_prefetch_queue
    import cpu_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    insn_prefetch_queue_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic            inflight_q, inflight_d;

    logic [CW-1:0]   fifo_count;
    logic [CW:0]     credit_used;
    fetch_entry_t    fifo_head;
    fetch_entry_t    rsp_entry;
    fetch_entry_t    out_entry;
    logic            fifo_vld;
    logic            rsp_vld;
    logic            out_vld;
    logic            issue;
    logic            push;
    logic            pop;

    // Slots are counted against entries held plus the one response in flight;
    // a pop only returns its credit once count_q has actually dropped.
    assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
    assign issue       = rst_n && !bus.redirect && (credit_used < (CW+1)'(DEPTH));

    assign rsp_vld     = inflight_q && !bus.redirect;
    assign rsp_entry   = '{pc: inflight_pc_q, insn: bus.imem_insn};
    assign fifo_vld    = (fifo_count != '0);

`ifdef PREFETCH_BYPASS_EN
    logic bypass;

    // An empty queue hands the returning word straight to decode; it is only
    // stored if decode cannot take it this cycle.
    assign bypass    = rsp_vld && !fifo_vld;
    assign out_vld   = fifo_vld || bypass;
    assign out_entry = fifo_vld ? fifo_head : rsp_entry;
    assign push      = rsp_vld && !(bypass && bus.id_ready);
    assign pop       = fifo_vld && bus.id_ready && !bus.redirect;
`else
    assign out_vld   = fifo_vld;
    assign out_entry = fifo_head;
    assign push      = rsp_vld;
    assign pop       = fifo_vld && bus.id_ready && !bus.redirect;
`endif

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = 1'b0;
        if (bus.redirect) begin
            fetch_pc_d = word_align(bus.redirect_pc);
        end else if (issue) begin
            fetch_pc_d    = fetch_pc_q + 32'd4;
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat (rsp_entry),
        .pop      (pop),
        .flush    (bus.redirect),
        .head     (fifo_head),
        .count    (fifo_count)
    );

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.id_valid  = out_vld;
    assign bus.id_insn   = out_vld ? out_entry.insn : NOP_INSN;
    assign bus.id_pc     = out_vld ? out_entry.pc   : '0;

endmodule

// File: tb/tb_insn_prefetch_queue.sv
// Scoreboard bench for insn_prefetch_queue: directed phases push expected PCs, a negedge monitor checks decode output.
module tb_insn_prefetch_queue;
    import cpu_pkg::*;

    // Memory returns addr ^ K so a swapped pc/insn pair is distinguishable.
    localparam logic [31:0] K = 32'hA5A5_0000;
`ifdef PREFETCH_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    insn_prefetch_queue_if bus ();
    insn_prefetch_queue_if bus2 ();

    insn_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    insn_prefetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    always @(posedge clk) begin
        bus.imem_insn  <= bus.imem_addr ^ K;
        bus2.imem_insn <= bus2.imem_addr ^ K;
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    int          rx_cnt = 0;
    int          rx2_cnt = 0;
    int          rx0;
    logic [31:0] exp_q[$];
    logic [31:0] exp2_q[$];
    logic [31:0] mon_e;
    logic [31:0] mon2_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_stream(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.id_valid && bus.id_ready && !bus.redirect) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_entry: got pc %h want none", bus.id_pc);
            end else begin
                mon_e = exp_q.pop_front();
                check("id_pc", bus.id_pc, mon_e);
                check("id_insn", bus.id_insn, mon_e ^ K);
            end
            rx_cnt++;
        end
        if (rst_n && bus2.id_valid && exp2_q.size() > 0) begin
            mon2_e = exp2_q.pop_front();
            check("wrap_pc", bus2.id_pc, mon2_e);
            check("wrap_insn", bus2.id_insn, mon2_e ^ K);
            rx2_cnt++;
        end
    end

    initial begin
        rst_n            = 1'b0;
        bus.redirect     = 1'b0;
        bus.redirect_pc  = '0;
        bus.id_ready     = 1'b1;
        bus2.redirect    = 1'b0;
        bus2.redirect_pc = '0;
        bus2.id_ready    = 1'b1;
        tick(2);

        check("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
        check("rst_imem_addr", bus.imem_addr, 32'h0);
        check("rst_id_valid", {31'd0, bus.id_valid}, 32'd0);
        check("rst_id_insn", bus.id_insn, NOP_INSN);
        check("rst_id_pc", bus.id_pc, 32'h0);
        check("rst2_imem_addr", bus2.imem_addr, 32'hFFFF_FFF8);

        // Streaming from reset, decode always ready.
        push_stream(32'h0, 64);
        exp2_q.push_back(32'hFFFF_FFF8);
        exp2_q.push_back(32'hFFFF_FFFC);
        exp2_q.push_back(32'h0000_0000);
        rst_n = 1'b1;
        #1;
        check("first_req", {31'd0, bus.imem_req}, 32'd1);
        check("first_addr", bus.imem_addr, 32'h0);
        tick(1);
        check("lat_c1_valid", {31'd0, bus.id_valid}, 32'(BYP));
`ifdef PREFETCH_BYPASS_EN
        check("bypass_count", 32'(dut.fifo_count), 32'd0);
`endif
        tick(1);
        check("lat_c2_valid", {31'd0, bus.id_valid}, 32'd1);
        rx0 = rx_cnt;
        tick(10);
        check("throughput", 32'(rx_cnt - rx0), 32'd10);

        // Decode stall: credit must cap outstanding work at DEPTH.
        bus.id_ready = 1'b0;
        tick(10);
        check("stall_req", {31'd0, bus.imem_req}, 32'd0);
        check("stall_count", 32'(dut.fifo_count), 32'd4);
        check("stall_valid", {31'd0, bus.id_valid}, 32'd1);
        rx0 = rx_cnt;
        bus.id_ready = 1'b1;
        tick(8);
        check("resume_rx", 32'(rx_cnt - rx0), 32'd8);

        // Redirect with 3 queued and 1 in flight.
        rst_n = 1'b0;
        bus.id_ready = 1'b0;
        tick(1);
        exp_q.delete();
        rst_n = 1'b1;
        tick(4);
        check("rd_setup_count", 32'(dut.fifo_count), 32'd3);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0100;
        #1;
        check("rd_no_req", {31'd0, bus.imem_req}, 32'd0);
        push_stream(32'h100, 64);
        tick(1);
        bus.redirect = 1'b0;
        bus.id_ready = 1'b1;
        #1;
        check("rd_r1_valid", {31'd0, bus.id_valid}, 32'd0);
        check("rd_r1_req", {31'd0, bus.imem_req}, 32'd1);
        check("rd_r1_addr", bus.imem_addr, 32'h100);
        tick(1);
        check("rd_r2_valid", {31'd0, bus.id_valid}, 32'(BYP));
        tick(1);
        check("rd_r3_valid", {31'd0, bus.id_valid}, 32'd1);

        // Redirect coinciding with a pop, unaligned target.
        tick(5);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0203;
        #1;
        check("rp_valid", {31'd0, bus.id_valid}, 32'd1);
        exp_q.delete();
        push_stream(32'h200, 64);
        rx0 = rx_cnt;
        tick(1);
        bus.redirect = 1'b0;
        #1;
        check("rp_req", {31'd0, bus.imem_req}, 32'd1);
        check("rp_addr", bus.imem_addr, 32'h200);
        check("rp_r1_valid", {31'd0, bus.id_valid}, 32'd0);
        tick(5);
        check("rp_rx", 32'(rx_cnt - rx0), 32'(3 + BYP));

        // Asynchronous reset with a full queue.
        bus.id_ready = 1'b0;
        tick(8);
        check("full_count", 32'(dut.fifo_count), 32'd4);
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, bus.id_valid}, 32'd0);
        check("arst_insn", bus.id_insn, NOP_INSN);
        check("arst_pc", bus.id_pc, 32'h0);
        check("arst_req", {31'd0, bus.imem_req}, 32'd0);
        check("arst_addr", bus.imem_addr, 32'h0);
        exp_q.delete();
        push_stream(32'h0, 64);
        tick(1);
        rst_n = 1'b1;
        bus.id_ready = 1'b1;
        #1;
        check("rerun_req", {31'd0, bus.imem_req}, 32'd1);
        check("rerun_addr", bus.imem_addr, 32'h0);
        rx0 = rx_cnt;
        tick(6);
        check("rerun_rx", 32'(rx_cnt - rx0), 32'(4 + BYP));

        check("wrap_rx", 32'(rx2_cnt), 32'd3);
        check("wrap_left", 32'(exp2_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
